// File: rtl/dec_driver.sv
// dec_driver: LFSR-driven RV32 instruction generator feeding a decoder, NUM_TRANS words per run.
// Build option DEC_DRIVER_ILLEGAL_EN: the word is replaced by zero whenever trans_cnt[2:0]==7.
module dec_driver #(
  parameter int unsigned NUM_TRANS   = 10,
  parameter logic [31:0] SEED        = 32'hACE1_2024,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        stall_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_rdata_alu_o,
  output logic        instr_first_cycle_o,
  output logic        illegal_c_insn_o,
  output logic        branch_taken_o,
  output logic        instr_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] trans_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DONE} state_e;

  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam logic [15:0] LAST_CNT  = 16'(NUM_TRANS);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 2);
  localparam logic [2:0]  CLS_BEQ   = 3'd4;
  localparam logic [2:0]  CLS_MUL   = 3'd7;

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [2:0]  cls_q, cls_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [31:0] rdata_q, rdata_d;
  logic        first_q, first_d;
  logic        taken_q, taken_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        retire;
  logic [31:0] word;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // The 12-bit field s[26:15] is the low part of every immediate; bits it cannot
  // reach (B/J bit 0 aside) are zero, and for LUI it fills imm[23:12].
  function automatic logic [31:0] encode(input logic [2:0] cls, input logic [26:0] s);
    logic [31:0] w;
    case (cls)
      3'd0:    w = {s[26:15], s[9:5], 3'b000, s[4:0], 7'h13};
      3'd1:    w = {7'h00, s[14:10], s[9:5], 3'b000, s[4:0], 7'h33};
      3'd2:    w = {s[26:15], s[9:5], 3'b010, s[4:0], 7'h03};
      3'd3:    w = {s[26:20], s[14:10], s[9:5], 3'b010, s[19:15], 7'h23};
      3'd4:    w = {1'b0, s[25:20], s[14:10], s[9:5], 3'b000, s[19:16], s[26], 7'h63};
      3'd5:    w = {1'b0, s[25:16], s[26], 8'h00, s[4:0], 7'h6F};
      3'd6:    w = {8'h00, s[26:15], s[4:0], 7'h37};
      default: w = {7'h01, s[14:10], s[9:5], 3'b000, s[4:0], 7'h33};
    endcase
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    retire  = 1'b0;

    if (!stall_i) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = ISSUE;
            lfsr_d  = SEED;
            cls_d   = '0;
            cnt_d   = '0;
          end
        end
        ISSUE: begin
          if (cls_q == CLS_BEQ || cls_q == CLS_MUL) begin
            state_d = HOLD;
            hold_d  = HOLD_LAST;
          end else begin
            retire = 1'b1;
          end
        end
        HOLD: begin
          if (hold_q == '0) retire = 1'b1;
          else              hold_d = hold_q - 16'd1;
        end
        DONE: begin
          if (!start_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (retire) begin
        lfsr_d  = lfsr_step(lfsr_q);
        cls_d   = cls_q + 3'd1;
        state_d = ISSUE;
        if (cnt_q < LAST_CNT) cnt_d = cnt_q + 16'd1;
        if (cnt_d == LAST_CNT) state_d = DONE;
      end
    end
  end

  always_comb begin
    word = encode(cls_d, lfsr_d[26:0]);
`ifdef DEC_DRIVER_ILLEGAL_EN
    if (cnt_d[2:0] == 3'd7) word = '0;
`endif
  end

  // Outputs are computed from next state so they are registered alongside it;
  // a stall holds everything except first_cycle, which drops after one cycle.
  always_comb begin
    rdata_d = '0;
    first_d = 1'b0;
    taken_d = 1'b0;
    valid_d = 1'b0;
    busy_d  = (state_d == ISSUE) || (state_d == HOLD);
    done_d  = (state_d == DONE);
    if (stall_i) begin
      rdata_d = rdata_q;
      taken_d = taken_q;
      valid_d = valid_q;
    end else begin
      case (state_d)
        ISSUE: begin
          rdata_d = word;
          first_d = 1'b1;
          valid_d = 1'b1;
        end
        HOLD: begin
          rdata_d = rdata_q;
          valid_d = 1'b1;
          taken_d = (cls_d == CLS_BEQ) && lfsr_d[31];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cls_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      rdata_q <= '0;
      first_q <= 1'b0;
      taken_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
      first_q <= first_d;
      taken_q <= taken_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign instr_rdata_o       = rdata_q;
  assign instr_rdata_alu_o   = rdata_q;
  assign instr_first_cycle_o = first_q;
  assign illegal_c_insn_o    = 1'b0;
  assign branch_taken_o      = taken_q;
  assign instr_valid_o       = valid_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign trans_cnt_o         = cnt_q;

endmodule

// File: tb/tb_dec_driver.sv
// Directed bench for dec_driver: instance A (NUM_TRANS=8, HOLD_CYCLES=2), instance B (NUM_TRANS=16, HOLD_CYCLES=3).
module tb_dec_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, stall_a, start_b, stall_b;
  logic [31:0] rdata_a, alu_a, rdata_b, alu_b;
  logic        first_a, ill_a, bt_a, valid_a, busy_a, done_a;
  logic        first_b, ill_b, bt_b, valid_b, busy_b, done_b;
  logic [15:0] cnt_a, cnt_b;

  int checks   = 0;
  int failures = 0;

`ifdef DEC_DRIVER_ILLEGAL_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  dec_driver #(.NUM_TRANS(8), .SEED(32'hACE1_2024), .HOLD_CYCLES(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .stall_i(stall_a),
    .instr_rdata_o(rdata_a), .instr_rdata_alu_o(alu_a), .instr_first_cycle_o(first_a),
    .illegal_c_insn_o(ill_a), .branch_taken_o(bt_a), .instr_valid_o(valid_a),
    .busy_o(busy_a), .done_o(done_a), .trans_cnt_o(cnt_a)
  );

  dec_driver #(.NUM_TRANS(16), .SEED(32'hACE1_2024), .HOLD_CYCLES(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .stall_i(stall_b),
    .instr_rdata_o(rdata_b), .instr_rdata_alu_o(alu_b), .instr_first_cycle_o(first_b),
    .illegal_c_insn_o(ill_b), .branch_taken_o(bt_b), .instr_valid_o(valid_b),
    .busy_o(busy_b), .done_o(done_b), .trans_cnt_o(cnt_b)
  );

  // Hand-decoded run for SEED 0xACE12024: ADDI ADD LW SW BEQ(x2) JAL LUI MUL(x2)
  logic [31:0] EXP_WORD [10] = '{32'h9C20_8213, 32'h0040_0933, 32'h6700_2483, 32'hB690_2C23,
                                 32'h5E48_0E63, 32'h5E48_0E63, 32'h2FF0_006F, 32'h0057_F037,
                                 32'h0309_0033, 32'h0309_0033};
  logic [0:9]  EXP_FIRST = 10'b11111_01110;
  logic [0:9]  EXP_BT    = 10'b00000_10000;
  int          EXP_CNT [10] = '{0, 1, 2, 3, 4, 4, 5, 6, 7, 7};

  task automatic wait_done_a(input string name);
    for (int k = 0; k < 100 && !done_a; k++) @(negedge clk);
    checks++;
    if (done_a !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout: done=%b required 1", name, done_a);
    end
    start_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rdata_a, alu_a, first_a, ill_a, bt_a, valid_a, busy_a, done_a, cnt_a} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdata=%h first=%b valid=%b busy=%b done=%b cnt=%0d required all 0",
               rdata_a, first_a, valid_a, busy_a, done_a, cnt_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid_a, busy_a, done_a, rdata_a} !== '0) begin
      failures++;
      $display("FAIL idle_no_start: valid=%b busy=%b done=%b rdata=%h required 0", valid_a, busy_a, done_a, rdata_a);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] ew;
    start_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ew = (ILL && i >= 8) ? 32'h0 : EXP_WORD[i];
      checks++;
      if ({rdata_a, alu_a} !== {ew, ew}) begin
        failures++;
        $display("FAIL seq_word[%0d]: rdata=%h alu=%h required %h", i, rdata_a, alu_a, ew);
      end
      checks++;
      if ({first_a, bt_a, valid_a, busy_a, done_a, ill_a, cnt_a} !==
          {EXP_FIRST[i], EXP_BT[i], 4'b1100, 16'(EXP_CNT[i])}) begin
        failures++;
        $display("FAIL seq_status[%0d]: first=%b bt=%b valid=%b busy=%b done=%b cnt=%0d required first=%b bt=%b valid=1 busy=1 done=0 cnt=%0d",
                 i, first_a, bt_a, valid_a, busy_a, done_a, cnt_a, EXP_FIRST[i], EXP_BT[i], EXP_CNT[i]);
      end
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      checks++;
      if ({done_a, valid_a, busy_a, first_a, rdata_a, cnt_a} !== {4'b1000, 32'h0, 16'd8}) begin
        failures++;
        $display("FAIL done_state[%0d]: done=%b valid=%b busy=%b rdata=%h cnt=%0d required done=1 valid=0 busy=0 rdata=0 cnt=8",
                 j, done_a, valid_a, busy_a, rdata_a, cnt_a);
      end
    end
    start_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_a, valid_a, busy_a} !== 3'b000) begin
      failures++;
      $display("FAIL done_to_idle: done=%b valid=%b busy=%b required 0", done_a, valid_a, busy_a);
    end
  endtask

  task automatic test_stall();
    start_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdata_a, cnt_a} !== {32'h9C20_8213, 16'd0}) begin
      failures++;
      $display("FAIL restart_first: rdata=%h cnt=%0d required 9c208213 cnt=0", rdata_a, cnt_a);
    end
    @(negedge clk);
    stall_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall_a = 1'b0;
      checks++;
      if ({rdata_a, first_a, valid_a, cnt_a} !== {32'h0040_0933, (i == 0), 1'b1, 16'd1}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: rdata=%h first=%b valid=%b cnt=%0d required 00400933 first=%b valid=1 cnt=1",
                 i, rdata_a, first_a, valid_a, cnt_a, (i == 0));
      end
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if ({rdata_a, first_a, cnt_a} !== {32'h6700_2483, 1'b1, 16'd2}) begin
      failures++;
      $display("FAIL stall_release: rdata=%h first=%b cnt=%0d required 67002483 first=1 cnt=2", rdata_a, first_a, cnt_a);
    end
    wait_done_a("stall");
  endtask

  task automatic test_start_drop();
    int nv;
    nv = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 60 && !done_a; k++) begin
      if (valid_a) nv++;
      @(negedge clk);
    end
    checks++;
    if (nv != 10 || done_a !== 1'b1 || cnt_a !== 16'd8) begin
      failures++;
      $display("FAIL start_drop_run: valid_cycles=%0d done=%b cnt=%0d required 10 cycles done=1 cnt=8", nv, done_a, cnt_a);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 60 && cnt_a != 16'd5; k++) @(negedge clk);
    checks++;
    if (cnt_a !== 16'd5 || valid_a !== 1'b1) begin
      failures++;
      $display("FAIL midrun_reach5: cnt=%0d valid=%b required cnt=5 valid=1", cnt_a, valid_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdata_a, alu_a, first_a, bt_a, valid_a, busy_a, done_a, cnt_a} !== '0) begin
      failures++;
      $display("FAIL midrun_async_reset: rdata=%h valid=%b busy=%b cnt=%0d required all 0", rdata_a, valid_a, busy_a, cnt_a);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdata_a, first_a, cnt_a} !== {32'h9C20_8213, 1'b1, 16'd0}) begin
      failures++;
      $display("FAIL midrun_restart: rdata=%h first=%b cnt=%0d required 9c208213 first=1 cnt=0", rdata_a, first_a, cnt_a);
    end
    wait_done_a("midrun");
  endtask

  task automatic test_illegal();
    int nv, ni;
    logic [31:0] ew;
    nv = 0;
    ni = 0;
    start_b = 1'b1;
    for (int k = 0; k < 200 && !done_b; k++) begin
      @(negedge clk);
      if (valid_b) nv++;
      if (valid_b && first_b) begin
        ni++;
        checks++;
        if (ni == 1 || ni == 9) begin
          ew = (ni == 1) ? 32'h9C20_8213 : 32'h95F4_8013;
          if (rdata_b !== ew) begin
            failures++;
            $display("FAIL b_word[%0d]: rdata=%h required %h", ni, rdata_b, ew);
          end
        end else if (ILL && (ni % 8 == 0)) begin
          if (rdata_b !== 32'h0) begin
            failures++;
            $display("FAIL b_illegal[%0d]: rdata=%h required 00000000", ni, rdata_b);
          end
        end else if (rdata_b === 32'h0 || $isunknown(rdata_b)) begin
          failures++;
          $display("FAIL b_nonzero[%0d]: rdata=%h required nonzero", ni, rdata_b);
        end
      end
    end
    checks++;
    if (ni != 16 || nv != 24 || done_b !== 1'b1 || cnt_b !== 16'd16) begin
      failures++;
      $display("FAIL b_run: instrs=%0d valid_cycles=%0d done=%b cnt=%0d required 16 instrs 24 cycles done=1 cnt=16",
               ni, nv, done_b, cnt_b);
    end
    start_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    stall_a = 1'b0;
    start_b = 1'b0;
    stall_b = 1'b0;
    test_reset();
    test_sequence();
    test_stall();
    test_start_drop();
    test_reset_midrun();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_driver.md
DEC_DRIVER -- requirements
Module: dec_driver

Interface
REQ-001 SHALL provide parameter NUM_TRANS, default 10: instructions issued per run, range 1..65535.
REQ-002 SHALL provide parameter SEED, default 32'hACE1_2024: initial LFSR state, nonzero.
REQ-003 SHALL provide parameter HOLD_CYCLES, default 2: total presentation cycles for BRANCH/MUL classes, minimum 2.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1 bit: level request to run a sequence.
REQ-007 SHALL have port stall_i, input, 1 bit: freezes sequencing while high.
REQ-008 SHALL have port instr_rdata_o, output, 32 bits: instruction word driven to the decoder.
REQ-009 SHALL have port instr_rdata_alu_o, output, 32 bits: replica of instr_rdata_o.
REQ-010 SHALL have port instr_first_cycle_o, output, 1 bit: first presentation cycle of the current instruction.
REQ-011 SHALL have port illegal_c_insn_o, output, 1 bit: tied 0.
REQ-012 SHALL have port branch_taken_o, output, 1 bit: registered branch decision for BRANCH class.
REQ-013 SHALL have port instr_valid_o, output, 1 bit: an instruction is being presented.
REQ-014 SHALL have port busy_o, output, 1 bit: high in ISSUE or HOLD.
REQ-015 SHALL have port done_o, output, 1 bit: sequence complete.
REQ-016 SHALL have port trans_cnt_o, output, 16 bits: instructions completed in the current run.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, HOLD, DONE.
- IDLE->ISSUE on start_i=1.
- ISSUE->HOLD when class is BRANCH or MUL; otherwise ISSUE->ISSUE with the next instruction.
- HOLD->ISSUE after HOLD_CYCLES-1 HOLD cycles.
- Any state->DONE when trans_cnt reaches NUM_TRANS.
- DONE->IDLE on start_i=0.
REQ-018 SHALL sequence eight instruction classes round-robin from class 0, one class per instruction.
- 0 ADDI: opcode 0x13, funct3 0.
- 1 ADD: opcode 0x33, funct7 0.
- 2 LW: opcode 0x03, funct3 2.
- 3 SW: opcode 0x23, funct3 2.
- 4 BEQ: opcode 0x63, funct3 0.
- 5 JAL: opcode 0x6F.
- 6 LUI: opcode 0x37.
- 7 MUL: opcode 0x33, funct7 0x01, funct3 0.
REQ-019 SHALL take operand fields from the current LFSR state: rd=[4:0], rs1=[9:5], rs2=[14:10], 12-bit imm=[26:15].
- I/S/B/J/U immediates are packed per the RV32I formats from these bits.
- Upper immediate bits not covered by [26:15] are zero-extended.
REQ-020 SHALL use a 32-bit Galois LFSR with tap mask 32'h8020_0003, loaded with SEED at reset and at IDLE->ISSUE, advanced once per completed instruction.
REQ-021 SHALL make outputs valid one cycle after start_i is sampled high in IDLE: instr_valid_o=1 and instr_first_cycle_o=1 in every ISSUE cycle.
REQ-022 SHALL hold instr_rdata_o stable with instr_first_cycle_o=0 in HOLD.
REQ-023 SHALL assert branch_taken_o in the HOLD cycles of BRANCH class only, when LFSR[31]=1; it SHALL be 0 otherwise.
REQ-024 SHALL, while stall_i=1, freeze state, LFSR, class and counter; instr_rdata_o SHALL be held and instr_first_cycle_o SHALL be 0 after the first stalled cycle.
REQ-025 SHALL increment trans_cnt_o on the last presentation cycle of each instruction; the count saturates at NUM_TRANS.
REQ-026 SHALL, in DONE, drive done_o=1, instr_valid_o=0 and instr_rdata_o=0; done_o SHALL be 0 in all other states.
REQ-027 SHALL, on IDLE->ISSUE, clear trans_cnt_o and reset the class index to 0.
REQ-028 SHALL ignore start_i deassertion while in ISSUE or HOLD; the run always completes.

Reset
REQ-029 SHALL, on rst_ni=0 at any time including mid-run, immediately enter IDLE.
- LFSR=SEED, class=0.
- All outputs 0, including instr_rdata_o=32'h0 and trans_cnt_o=0.

Configuration
REQ-030 SHALL, with macro DEC_DRIVER_ILLEGAL_EN defined, replace the instruction word with 32'h0000_0000 whenever trans_cnt[2:0]==7; class advance and hold rules SHALL be unchanged.
REQ-031 SHALL, without DEC_DRIVER_ILLEGAL_EN, never emit 32'h0000_0000 while instr_valid_o=1.

Verification
REQ-032 Reset then start_i=1, default SEED -> first ISSUE cycle: instr_rdata_o=32'h9C20_8213 (ADDI x4,x1,0x9C2), instr_first_cycle_o=1.
REQ-033 NUM_TRANS=8, HOLD_CYCLES=2, no stall -> instr_valid_o high exactly 10 cycles, then done_o=1 and trans_cnt_o=8.
REQ-034 stall_i=1 for 3 cycles during an ADD -> word unchanged for 4 cycles, instr_first_cycle_o=1 then 0,0,0, trans_cnt_o unchanged.
REQ-035 rst_ni pulsed low at trans_cnt_o=5 -> outputs 0 and state IDLE immediately; next start_i reproduces 32'h9C20_8213.
REQ-036 DEC_DRIVER_ILLEGAL_EN, NUM_TRANS=16 -> instructions 8 and 16 are 32'h0, all others nonzero; without macro, all 16 nonzero.
